// File: rtl/prim_clock_meas_sched.sv
// prim_clock_meas_sched
//
// Round-robin scheduler that shares one clock-measurement channel among
// NumChan measured clocks. Each visit selects the next enabled channel,
// latches its select and thresholds, enables the measurement unit, drops the
// warm-up result, evaluates SampleCnt results and then idles for SettleCycles
// before moving on. FailThresh consecutive fast (slow) results set a sticky
// per-channel fast (slow) error.
//
// Ports:
//   clk_i, rst_ni        clock, synchronous active-low reset
//   en_i                 global scheduler enable
//   chan_en_i            per-channel enable
//   max_cnt_i/min_cnt_i  packed per-channel fast/slow thresholds
//   meas_sel_o           clock-mux select of the active channel
//   meas_en_o            measurement enable
//   meas_max/min_cnt_o   thresholds latched for the current visit
//   meas_valid_i         result-valid pulse; meas_fast_i/meas_slow_i qualify it
//   err_clr_i            per-channel clear of sticky errors and fail counters
//   fast_err_o/slow_err_o sticky per-channel errors
//   busy_o               FSM not idle
//   round_done_o         one-cycle pulse when a round completes
//   wdog_o               watchdog event pulse (only with the macro below)
//
// Optional feature: define PRIM_CLOCK_MEAS_SCHED_WATCHDOG_EN to add a
// watchdog that ends a visit (and flags both errors) when no valid pulse
// arrives within WatchdogCycles cycles.

module prim_clock_meas_sched #(
  parameter int NumChan        = 4,
  parameter int CntWidth       = 5,
  parameter int SampleCnt      = 4,
  parameter int FailThresh     = 2,
  parameter int SettleCycles   = 8,
  parameter int WatchdogCycles = 256
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         en_i,
  input  logic [NumChan-1:0]           chan_en_i,
  input  logic [NumChan*CntWidth-1:0]  max_cnt_i,
  input  logic [NumChan*CntWidth-1:0]  min_cnt_i,
  output logic [$clog2(NumChan)-1:0]   meas_sel_o,
  output logic                         meas_en_o,
  output logic [CntWidth-1:0]          meas_max_cnt_o,
  output logic [CntWidth-1:0]          meas_min_cnt_o,
  input  logic                         meas_valid_i,
  input  logic                         meas_fast_i,
  input  logic                         meas_slow_i,
  input  logic [NumChan-1:0]           err_clr_i,
  output logic [NumChan-1:0]           fast_err_o,
  output logic [NumChan-1:0]           slow_err_o,
  output logic                         busy_o,
  output logic                         round_done_o
`ifdef PRIM_CLOCK_MEAS_SCHED_WATCHDOG_EN
  ,
  output logic                         wdog_o
`endif
);

  localparam int SelW = $clog2(NumChan);
  localparam int ScW  = $clog2(SampleCnt + 2);
  localparam int StW  = $clog2(SettleCycles + 1);
  localparam int FcW  = $clog2(FailThresh + 1);

  if (NumChan < 2 || SampleCnt < 1 || FailThresh < 1 || SettleCycles < 1 ||
      WatchdogCycles < 1) begin : g_param_check
    $error("prim_clock_meas_sched: illegal parameter value");
  end

  typedef enum logic [1:0] {
    StIdle,
    StSelect,
    StMeasure,
    StSettle
  } state_e;

  state_e state_q, state_d;

  logic [SelW-1:0]     ptr_q, sel_q, next_chan;
  logic                next_found;
  logic [CntWidth-1:0] max_q, min_q;
  logic [ScW-1:0]      smp_q;
  logic [StW-1:0]      settle_q;
  logic [NumChan-1:0]  fast_err_q, slow_err_q;
  logic [FcW-1:0]      fast_cnt_q [NumChan];
  logic [FcW-1:0]      slow_cnt_q [NumChan];
  logic [FcW-1:0]      fast_cnt_nxt, slow_cnt_nxt;

  logic abort, meas_active, eval, last_eval, settle_done, higher_en;
  logic set_fast, set_slow, wdog_fire;

  // Next enabled channel strictly after the last-served one; a lone enabled
  // channel wraps around onto itself.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    next_chan  = ptr_q;
    next_found = 1'b0;
    for (int i = 1; i <= NumChan; i++) begin
      if (!next_found && chan_en_i[(int'(ptr_q) + i) % NumChan]) begin
        next_found = 1'b1;
        next_chan  = SelW'((int'(ptr_q) + i) % NumChan);
      end
    end
  end

  always_comb begin
    higher_en = 1'b0;
    for (int j = 0; j < NumChan; j++) begin
      if (j > int'(sel_q) && chan_en_i[j]) higher_en = 1'b1;
    end
  end

  // Abort has priority over a coinciding valid: that sample is dropped.
  assign abort       = (state_q == StMeasure) && (!en_i || !chan_en_i[sel_q]);
  assign meas_active = (state_q == StMeasure) && !abort;
  // smp_q counts valids seen this visit; the first (count 0) is the warm-up.
  assign eval        = meas_active && meas_valid_i && (smp_q != '0);
  assign last_eval   = eval && (smp_q == ScW'(SampleCnt));
  assign settle_done = (state_q == StSettle) && (settle_q == StW'(SettleCycles - 1));

  // Saturating fail counters of the active channel, evaluated from the old
  // value so a coinciding clear cannot mask a sample that reaches threshold.
  always_comb begin
    fast_cnt_nxt = '0;
    slow_cnt_nxt = '0;
    if (meas_fast_i) begin
      fast_cnt_nxt = (fast_cnt_q[sel_q] == FcW'(FailThresh)) ? fast_cnt_q[sel_q]
                                                             : fast_cnt_q[sel_q] + 1'b1;
    end
    if (meas_slow_i) begin
      slow_cnt_nxt = (slow_cnt_q[sel_q] == FcW'(FailThresh)) ? slow_cnt_q[sel_q]
                                                             : slow_cnt_q[sel_q] + 1'b1;
    end
  end

  assign set_fast = (eval && meas_fast_i && fast_cnt_nxt == FcW'(FailThresh)) || wdog_fire;
  assign set_slow = (eval && meas_slow_i && slow_cnt_nxt == FcW'(FailThresh)) || wdog_fire;

`ifdef PRIM_CLOCK_MEAS_SCHED_WATCHDOG_EN
  localparam int WdW = $clog2(WatchdogCycles + 1);
  logic [WdW-1:0] wdog_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wdog_q <= '0;
    end else if (state_q != StMeasure || meas_valid_i) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_q + 1'b1;
    end
  end

  assign wdog_fire = meas_active && !meas_valid_i && (wdog_q == WdW'(WatchdogCycles - 1));
  assign wdog_o    = wdog_fire;
`else
  assign wdog_fire = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (en_i && |chan_en_i) state_d = StSelect;
      StSelect:  state_d = (en_i && next_found) ? StMeasure : StIdle;
      StMeasure: if (abort || last_eval || wdog_fire) state_d = StSettle;
      StSettle:  if (settle_done) state_d = en_i ? StSelect : StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // flop samples the pre-edge values regardless of statement order.
      state_q  <= StIdle;
      ptr_q    <= SelW'(NumChan - 1);
      sel_q    <= '0;
      max_q    <= '0;
      min_q    <= '0;
      smp_q    <= '0;
      settle_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StSelect && state_d == StMeasure) begin
        sel_q <= next_chan;
        ptr_q <= next_chan;
        max_q <= max_cnt_i[int'(next_chan)*CntWidth +: CntWidth];
        min_q <= min_cnt_i[int'(next_chan)*CntWidth +: CntWidth];
        smp_q <= '0;
      end else if (meas_active && meas_valid_i) begin
        smp_q <= smp_q + 1'b1;
      end
      settle_q <= (state_q == StSettle) ? settle_q + 1'b1 : '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      fast_err_q <= '0;
      slow_err_q <= '0;
      // NOTE: the fail counters are an array but still control behaviour, so
      // every entry is reset explicitly rather than left as uninitialised RAM.
      for (int k = 0; k < NumChan; k++) begin
        fast_cnt_q[k] <= '0;
        slow_cnt_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NumChan; k++) begin
        if (eval && sel_q == SelW'(k)) begin
          fast_cnt_q[k] <= fast_cnt_nxt;
          slow_cnt_q[k] <= slow_cnt_nxt;
        end else if (err_clr_i[k]) begin
          fast_cnt_q[k] <= '0;
          slow_cnt_q[k] <= '0;
        end
        // A set in the same cycle as a clear wins.
        if (set_fast && sel_q == SelW'(k)) fast_err_q[k] <= 1'b1;
        else if (err_clr_i[k])             fast_err_q[k] <= 1'b0;
        if (set_slow && sel_q == SelW'(k)) slow_err_q[k] <= 1'b1;
        else if (err_clr_i[k])             slow_err_q[k] <= 1'b0;
      end
    end
  end

  assign meas_sel_o     = sel_q;
  assign meas_en_o      = (state_q == StMeasure);
  assign meas_max_cnt_o = max_q;
  assign meas_min_cnt_o = min_q;
  assign fast_err_o     = fast_err_q;
  assign slow_err_o     = slow_err_q;
  assign busy_o         = (state_q != StIdle);
  assign round_done_o   = settle_done && !higher_en;

endmodule

// File: tb/tb_prim_clock_meas_sched.sv
// Directed testbench for prim_clock_meas_sched (NumChan=4, CntWidth=5,
// SampleCnt=4, FailThresh=2, SettleCycles=8, WatchdogCycles=16).

module tb_prim_clock_meas_sched;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        en_i;
  logic [3:0]  chan_en_i;
  logic [19:0] max_cnt_i;
  logic [19:0] min_cnt_i;
  logic [1:0]  meas_sel_o;
  logic        meas_en_o;
  logic [4:0]  meas_max_cnt_o;
  logic [4:0]  meas_min_cnt_o;
  logic        meas_valid_i;
  logic        meas_fast_i;
  logic        meas_slow_i;
  logic [3:0]  err_clr_i;
  logic [3:0]  fast_err_o;
  logic [3:0]  slow_err_o;
  logic        busy_o;
  logic        round_done_o;
`ifdef PRIM_CLOCK_MEAS_SCHED_WATCHDOG_EN
  logic        wdog_o;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int rd_cnt  = 0;

  always #5 clk_i = ~clk_i;

  prim_clock_meas_sched #(
    .NumChan(4), .CntWidth(5), .SampleCnt(4), .FailThresh(2),
    .SettleCycles(8), .WatchdogCycles(16)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i), .chan_en_i(chan_en_i),
    .max_cnt_i(max_cnt_i), .min_cnt_i(min_cnt_i), .meas_sel_o(meas_sel_o),
    .meas_en_o(meas_en_o), .meas_max_cnt_o(meas_max_cnt_o),
    .meas_min_cnt_o(meas_min_cnt_o), .meas_valid_i(meas_valid_i),
    .meas_fast_i(meas_fast_i), .meas_slow_i(meas_slow_i),
    .err_clr_i(err_clr_i), .fast_err_o(fast_err_o), .slow_err_o(slow_err_o),
    .busy_o(busy_o), .round_done_o(round_done_o)
`ifdef PRIM_CLOCK_MEAS_SCHED_WATCHDOG_EN
    , .wdog_o(wdog_o)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_i);
  endtask

  // One-cycle valid pulse; returns at the negedge after the sampling edge.
  task automatic pulse(input logic f, input logic s);
    meas_valid_i = 1'b1;
    meas_fast_i  = f;
    meas_slow_i  = s;
    tick();
    meas_valid_i = 1'b0;
    meas_fast_i  = 1'b0;
    meas_slow_i  = 1'b0;
  endtask

  // Waits (bounded) for the next Measure, counting low cycles and round_done.
  task automatic next_visit(input string tag, input int exp_gap);
    int gap;
    gap = 0;
    while (!meas_en_o && gap < 64) begin
      if (round_done_o) rd_cnt++;
      tick();
      gap++;
    end
    check({tag, "_gap"}, gap, exp_gap);
  endtask

  // Full visit of 5 valids (one idle cycle between them) with the expected
  // sticky-error bits of the visited channel after each valid.
  task automatic visit_chk(input string tag, input int sel, input int max_exp,
                           input logic [4:0] fpat, input logic [4:0] spat,
                           input logic [4:0] efe, input logic [4:0] ese);
    check({tag, "_sel"}, meas_sel_o, sel);
    check({tag, "_max"}, meas_max_cnt_o, max_exp);
    check({tag, "_min"}, meas_min_cnt_o, sel + 2);
    for (int v = 0; v < 5; v++) begin
      pulse(fpat[v], spat[v]);
      check({tag, "_fe"}, fast_err_o[sel], efe[v]);
      check({tag, "_se"}, slow_err_o[sel], ese[v]);
      if (v == 3) check({tag, "_en_held"}, meas_en_o, 1);
      if (v < 4) tick();
    end
    check({tag, "_en_drop"}, meas_en_o, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

  initial begin
    rst_ni = 1'b0; en_i = 1'b0; chan_en_i = 4'b1011; err_clr_i = '0;
    meas_valid_i = 1'b0; meas_fast_i = 1'b0; meas_slow_i = 1'b0;
    max_cnt_i = {5'd13, 5'd12, 5'd11, 5'd10};
    min_cnt_i = {5'd5, 5'd4, 5'd3, 5'd2};
    repeat (3) tick();
    check("rst_sel", meas_sel_o, 0);
    check("rst_en", meas_en_o, 0);
    check("rst_max", meas_max_cnt_o, 0);
    check("rst_min", meas_min_cnt_o, 0);
    check("rst_ferr", fast_err_o, 0);
    check("rst_serr", slow_err_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_rd", round_done_o, 0);
    rst_ni = 1'b1;
    tick();
    check("idle_busy", busy_o, 0);

    // Round-robin over 1011: 0, 1, 3, 0 with two-cycle start latency.
    en_i = 1'b1;
    tick();
    check("lat_busy", busy_o, 1);
    check("lat_en0", meas_en_o, 0);
    tick();
    check("lat_en1", meas_en_o, 1);
    visit_chk("v0", 0, 10, '0, '0, '0, '0);
    next_visit("v1", 9);
    visit_chk("v1", 1, 11, '0, '0, '0, '0);
    next_visit("v3", 9);
    visit_chk("v3", 3, 13, '0, '0, '0, '0);
    check("rd_before", rd_cnt, 0);
    next_visit("v0b", 9);
    check("rd_round", rd_cnt, 1);
    visit_chk("v0b", 0, 10, '0, '0, '0, '0);
    check("no_ferr", fast_err_o, 0);
    check("no_serr", slow_err_o, 0);

    // Channel 2 only: fast on valids 2 and 3 sets the error at valid 3.
    chan_en_i = 4'b0100;
    next_visit("c2", 9);
    check("rd_c2", rd_cnt, 1);
    visit_chk("c2", 2, 12, 5'b00110, '0, 5'b11100, '0);
    err_clr_i = 4'b0100;
    tick();
    err_clr_i = '0;
    check("c2_clr", fast_err_o[2], 0);
    next_visit("c2b", 8);
    check("rd_c2b", rd_cnt, 2);
    visit_chk("c2alt", 2, 12, 5'b01010, '0, '0, '0);

    // Channel 1: both errors set, then set-vs-clear and clear alone.
    chan_en_i = 4'b0010;
    next_visit("c1", 9);
    check("rd_c1", rd_cnt, 3);
    visit_chk("c1", 1, 11, 5'b11000, 5'b11000, 5'b10000, 5'b10000);
    next_visit("c1b", 9);
    check("c1b_sel", meas_sel_o, 1);
    pulse(1'b0, 1'b0);
    tick();
    err_clr_i = 4'b0010;
    pulse(1'b1, 1'b0);
    err_clr_i = '0;
    check("set_wins", fast_err_o[1], 1);
    check("clr_slow", slow_err_o[1], 0);
    tick();
    err_clr_i = 4'b0010;
    tick();
    err_clr_i = '0;
    check("clr_alone", fast_err_o[1], 0);
    pulse(1'b1, 1'b0);
    check("cnt_cleared", fast_err_o[1], 0);
    tick();
    pulse(1'b0, 1'b0);
    tick();
    pulse(1'b0, 1'b0);
    check("c1b_end", meas_en_o, 0);

    // en_i dropped after 2 valids; valids during Settle are ignored.
    chan_en_i = 4'b1011;
    next_visit("c3", 9);
    check("c3_sel", meas_sel_o, 3);
    pulse(1'b0, 1'b0);
    tick();
    pulse(1'b1, 1'b1);
    check("c3_ferr0", fast_err_o[3], 0);
    en_i = 1'b0;
    tick();
    check("abort_en", meas_en_o, 0);
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) begin
        meas_valid_i = 1'b1; meas_fast_i = 1'b1; meas_slow_i = 1'b1;
      end
      tick();
      meas_valid_i = 1'b0; meas_fast_i = 1'b0; meas_slow_i = 1'b0;
      if (i == 6) check("settle_busy", busy_o, 1);
    end
    check("idle_after", busy_o, 0);
    check("settle_ign_f", fast_err_o[3], 0);
    check("settle_ign_s", slow_err_o[3], 0);

    // Channel-enable abort and threshold hold within a visit.
    en_i = 1'b1;
    tick();
    tick();
    check("t5_en", meas_en_o, 1);
    check("t5_sel", meas_sel_o, 0);
    pulse(1'b0, 1'b0);
    tick();
    pulse(1'b0, 1'b0);
    max_cnt_i[4:0] = 5'd25;
    tick();
    check("thr_hold", meas_max_cnt_o, 10);
    chan_en_i = 4'b1010;
    tick();
    check("abort_chan", meas_en_o, 0);
    chan_en_i = 4'b1011;
    next_visit("t5a", 9);
    visit_chk("t5a", 1, 11, '0, '0, '0, '0);
    next_visit("t5b", 9);
    visit_chk("t5b", 3, 13, '0, '0, '0, '0);
    next_visit("t5c", 9);
    visit_chk("t5c", 0, 25, '0, '0, '0, '0);

`ifdef PRIM_CLOCK_MEAS_SCHED_WATCHDOG_EN
    begin
      int n;
      chan_en_i = 4'b0001;
      next_visit("wd", 9);
      n = 1;
      while (!wdog_o && n < 40) begin
        tick();
        n++;
      end
      check("wd_cycle", n, 16);
      tick();
      check("wd_ferr", fast_err_o[0], 1);
      check("wd_serr", slow_err_o[0], 1);
      check("wd_settle", meas_en_o, 0);
      next_visit("wd_next", 9);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
